// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared definitions for the CPU/DMA data-RAM arbiter.
//   - grant state encoding (IDLE, G_CPU, G_DMA)
//   - requester ids used to remember who was granted most recently
//   - RAM window bounds in CPU byte-address space
//   - request bundle struct used to mux the granted requester onto the RAM
package ram_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    G_CPU = 2'd1,
    G_DMA = 2'd2
  } arb_state_e;

  localparam logic REQ_CPU = 1'b0;
  localparam logic REQ_DMA = 1'b1;

  // RAM occupies byte addresses [BOUND_L, BOUND_U).
  localparam logic [15:0] BOUND_L = 16'h0200;
  localparam logic [15:0] BOUND_U = 16'h0400;

  typedef struct packed {
    logic [15:0] addr;
    logic [15:0] din;
    logic        rw;   // 1 = write
    logic        bw;   // 1 = byte
  } arb_req_t;

endpackage

// File: rtl/ram_arb_range.sv
// ram_arb_range: combinational RAM-window check for one access.
//   addr     in  16  CPU-space byte address
//   bw       in  1   1 = byte access, 0 = word access
//   in_range out 1   access lies entirely inside [BOUND_L, BOUND_U)
// Only instantiated when RAM_ARB_RANGE_CHECK_EN is defined.
module ram_arb_range
  import ram_arbiter_pkg::*;
(
  input  logic [15:0] addr,
  input  logic        bw,
  output logic        in_range
);

  always_comb begin
    in_range = 1'b1;
    if (addr < BOUND_L)                          in_range = 1'b0;
    else if (bw  && (addr > (BOUND_U - 16'd1))) in_range = 1'b0;
    // a word touches addr and addr+1, so its last legal start is one lower
    else if (!bw && (addr > (BOUND_U - 16'd2))) in_range = 1'b0;
  end

endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: shares the single-ported data RAM between CPU and DMA.
// Each access gets a one-cycle grant; the following cycle carries a
// registered ack plus read data. CPU-space addresses are translated to
// RAM indices (addr - BOUND_L, mod 2^16).
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   {cpu,dma}_req/addr/din/rw/bw  requester inputs (held until ack)
//   {cpu,dma}_gnt              requester's RAM access cycle
//   {cpu,dma}_ack/rdata        one-cycle ack with registered read data
//   err                        ack'd access was out of range
//   ram_addr/ram_Din/ram_RW/BW RAM control, combinational from grant
//   ram_out                    combinational RAM read data
// Build option: RAM_ARB_RANGE_CHECK_EN enables the out-of-range check
// (suppresses the write, returns zero data, pulses err with the ack).
module ram_arbiter
  import ram_arbiter_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_req,
  input  logic [15:0] cpu_addr,
  input  logic [15:0] cpu_din,
  input  logic        cpu_rw,
  input  logic        cpu_bw,
  input  logic        dma_req,
  input  logic [15:0] dma_addr,
  input  logic [15:0] dma_din,
  input  logic        dma_rw,
  input  logic        dma_bw,
  output logic        cpu_gnt,
  output logic        dma_gnt,
  output logic        cpu_ack,
  output logic        dma_ack,
  output logic [15:0] cpu_rdata,
  output logic [15:0] dma_rdata,
  output logic        err,
  output logic [15:0] ram_addr,
  output logic [15:0] ram_Din,
  output logic        ram_RW,
  output logic        BW,
  input  logic [15:0] ram_out
);

  arb_state_e  state_q, state_d;
  logic        last_q, last_d;
  logic        cpu_elig, dma_elig;
  logic        any_gnt, sel_in_range;
  arb_req_t    cpu_r, dma_r, sel;
  logic [15:0] rd_val;
  logic        cpu_ack_q, cpu_ack_d, dma_ack_q, dma_ack_d, err_q, err_d;
  logic [15:0] cpu_rdata_q, cpu_rdata_d, dma_rdata_q, dma_rdata_d;

  assign cpu_r = '{addr: cpu_addr, din: cpu_din, rw: cpu_rw, bw: cpu_bw};
  assign dma_r = '{addr: dma_addr, din: dma_din, rw: dma_rw, bw: dma_bw};

  // State register; last_q resets to DMA so the CPU wins the first tie.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      last_q  <= REQ_DMA;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
    end
  end

  // Next state. The requester granted in the ending cycle is not eligible,
  // so it is never regranted before it has seen its ack.
  always_comb begin
    cpu_elig = cpu_req && (state_q != G_CPU);
    dma_elig = dma_req && (state_q != G_DMA);
    state_d  = IDLE;
    if (cpu_elig && dma_elig) state_d = (last_q == REQ_DMA) ? G_CPU : G_DMA;
    else if (cpu_elig)        state_d = G_CPU;
    else if (dma_elig)        state_d = G_DMA;
    last_d = last_q;
    if (state_d == G_CPU) last_d = REQ_CPU;
    if (state_d == G_DMA) last_d = REQ_DMA;
  end

  // Outputs: RAM port driven from the granted requester, all zero in IDLE.
  always_comb begin
    cpu_gnt  = (state_q == G_CPU);
    dma_gnt  = (state_q == G_DMA);
    any_gnt  = cpu_gnt | dma_gnt;
    sel      = '0;
    if (cpu_gnt)      sel = cpu_r;
    else if (dma_gnt) sel = dma_r;
    ram_addr = any_gnt ? (sel.addr - BOUND_L) : 16'h0000;
    ram_Din  = sel.din;
    BW       = sel.bw;
    ram_RW   = sel.rw & any_gnt & sel_in_range;
  end

`ifdef RAM_ARB_RANGE_CHECK_EN
  ram_arb_range u_range (
    .addr     (sel.addr),
    .bw       (sel.bw),
    .in_range (sel_in_range)
  );
`else
  assign sel_in_range = 1'b1;
`endif

  // Ack/read-data capture at the edge ending the grant cycle. Writes also
  // return the old RAM contents; byte reads zero-extend the low lane.
  always_comb begin
    if (!sel_in_range) rd_val = 16'h0000;
    else if (sel.bw)   rd_val = {8'h00, ram_out[7:0]};
    else               rd_val = ram_out;
    cpu_ack_d   = cpu_gnt;
    dma_ack_d   = dma_gnt;
    err_d       = any_gnt & ~sel_in_range;
    cpu_rdata_d = cpu_gnt ? rd_val : cpu_rdata_q;
    dma_rdata_d = dma_gnt ? rd_val : dma_rdata_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_ack_q   <= 1'b0;
      dma_ack_q   <= 1'b0;
      err_q       <= 1'b0;
      cpu_rdata_q <= 16'h0000;
      dma_rdata_q <= 16'h0000;
    end else begin
      cpu_ack_q   <= cpu_ack_d;
      dma_ack_q   <= dma_ack_d;
      err_q       <= err_d;
      cpu_rdata_q <= cpu_rdata_d;
      dma_rdata_q <= dma_rdata_d;
    end
  end

  assign cpu_ack   = cpu_ack_q;
  assign dma_ack   = dma_ack_q;
  assign err       = err_q;
  assign cpu_rdata = cpu_rdata_q;
  assign dma_rdata = dma_rdata_q;

endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: scoreboard bench for ram_arbiter. Drivers push expected
// {rdata, err} from a CPU-address-space memory model; a negedge monitor
// pops on every ack and also checks grant exclusivity, ack timing and
// the RAM port contents during each grant.
`timescale 1ns/1ps
module tb_ram_arbiter;
  import ram_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_req = 0, cpu_rw = 0, cpu_bw = 0;
  logic [15:0] cpu_addr = 0, cpu_din = 0;
  logic        dma_req = 0, dma_rw = 0, dma_bw = 0;
  logic [15:0] dma_addr = 0, dma_din = 0;
  logic        cpu_gnt, dma_gnt, cpu_ack, dma_ack, err, ram_RW, BW;
  logic [15:0] cpu_rdata, dma_rdata, ram_addr, ram_Din, ram_out;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_req(cpu_req), .cpu_addr(cpu_addr), .cpu_din(cpu_din), .cpu_rw(cpu_rw), .cpu_bw(cpu_bw),
    .dma_req(dma_req), .dma_addr(dma_addr), .dma_din(dma_din), .dma_rw(dma_rw), .dma_bw(dma_bw),
    .cpu_gnt(cpu_gnt), .dma_gnt(dma_gnt), .cpu_ack(cpu_ack), .dma_ack(dma_ack),
    .cpu_rdata(cpu_rdata), .dma_rdata(dma_rdata), .err(err),
    .ram_addr(ram_addr), .ram_Din(ram_Din), .ram_RW(ram_RW), .BW(BW), .ram_out(ram_out)
  );

  // RAM device, indexed by RAM index; presents the word at ram_addr.
  logic [7:0] mem  [65536];
  // Reference memory, indexed by CPU byte address.
  logic [7:0] rmem [65536];

  assign ram_out = {mem[ram_addr + 16'd1], mem[ram_addr]};
  always @(posedge clk) begin
    if (ram_RW) begin
      mem[ram_addr] <= ram_Din[7:0];
      if (!BW) mem[ram_addr + 16'd1] <= ram_Din[15:8];
    end
  end

  typedef struct { logic [15:0] rdata; logic err; } exp_t;
  exp_t cpu_q[$];
  exp_t dma_q[$];
  int   n_chk = 0, n_fail = 0;
  logic [1:0] glog[$];
  bit   log_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic tb_in_range(input logic [15:0] a, input logic bw);
`ifdef RAM_ARB_RANGE_CHECK_EN
    if (a < 16'h0200) return 1'b0;
    if (bw) return a <= 16'h03FF;
    return a <= 16'h03FE;
`else
    return 1'b1;
`endif
  endfunction

  // Spec-level access: returns expected ack contents and updates rmem.
  function automatic exp_t model(input logic [15:0] a, d, input logic rw, bw);
    exp_t e;
    logic [15:0] old;
    if (!tb_in_range(a, bw)) begin
      e.rdata = 16'h0000; e.err = 1'b1;
      return e;
    end
    old     = {rmem[a + 16'd1], rmem[a]};
    e.rdata = bw ? {8'h00, old[7:0]} : old;
    e.err   = 1'b0;
    if (rw) begin
      rmem[a] = d[7:0];
      if (!bw) rmem[a + 16'd1] = d[15:8];
    end
    return e;
  endfunction

  // Drivers: called at a negedge; return at the negedge of the ack cycle.
  task automatic cpu_access(input logic [15:0] a, d, input logic rw, bw, output int lat);
    cpu_addr = a; cpu_din = d; cpu_rw = rw; cpu_bw = bw; cpu_req = 1'b1;
    cpu_q.push_back(model(a, d, rw, bw));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!cpu_ack && lat < 50);
    if (!cpu_ack) chk("cpu_ack_timeout", 32'd0, 32'd1);
  endtask

  task automatic dma_access(input logic [15:0] a, d, input logic rw, bw, output int lat);
    dma_addr = a; dma_din = d; dma_rw = rw; dma_bw = bw; dma_req = 1'b1;
    dma_q.push_back(model(a, d, rw, bw));
    lat = 0;
    do begin @(negedge clk); lat++; end while (!dma_ack && lat < 50);
    if (!dma_ack) chk("dma_ack_timeout", 32'd0, 32'd1);
  endtask

  // Monitor.
  logic pc = 0, pd = 0;
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pc <= 1'b0; pd <= 1'b0;
    end else begin
      chk("one_gnt", {31'd0, cpu_gnt & dma_gnt}, 32'd0);
      chk("cpu_ack_timing", {31'd0, cpu_ack}, {31'd0, pc});
      chk("dma_ack_timing", {31'd0, dma_ack}, {31'd0, pd});
      if (pc) chk("cpu_no_regrant", {31'd0, cpu_gnt}, 32'd0);
      if (pd) chk("dma_no_regrant", {31'd0, dma_gnt}, 32'd0);
      if (cpu_gnt) begin
        chk("cpu_ram_addr", {16'd0, ram_addr}, {16'd0, cpu_addr - 16'h0200});
        chk("cpu_ram_din",  {16'd0, ram_Din}, {16'd0, cpu_din});
        chk("cpu_ram_bw",   {31'd0, BW}, {31'd0, cpu_bw});
        chk("cpu_ram_rw",   {31'd0, ram_RW}, {31'd0, cpu_rw & tb_in_range(cpu_addr, cpu_bw)});
      end else if (dma_gnt) begin
        chk("dma_ram_addr", {16'd0, ram_addr}, {16'd0, dma_addr - 16'h0200});
        chk("dma_ram_din",  {16'd0, ram_Din}, {16'd0, dma_din});
        chk("dma_ram_bw",   {31'd0, BW}, {31'd0, dma_bw});
        chk("dma_ram_rw",   {31'd0, ram_RW}, {31'd0, dma_rw & tb_in_range(dma_addr, dma_bw)});
      end else begin
        chk("idle_ram_port", {ram_addr, ram_Din}, 32'd0);
        chk("idle_ram_ctl",  {30'd0, ram_RW, BW}, 32'd0);
      end
      if (cpu_ack) begin
        if (cpu_q.size() == 0) chk("cpu_spurious_ack", 32'd1, 32'd0);
        else begin
          e = cpu_q.pop_front();
          chk("cpu_rdata", {16'd0, cpu_rdata}, {16'd0, e.rdata});
          chk("cpu_err",   {31'd0, err}, {31'd0, e.err});
        end
      end
      if (dma_ack) begin
        if (dma_q.size() == 0) chk("dma_spurious_ack", 32'd1, 32'd0);
        else begin
          e = dma_q.pop_front();
          chk("dma_rdata", {16'd0, dma_rdata}, {16'd0, e.rdata});
          chk("dma_err",   {31'd0, err}, {31'd0, e.err});
        end
      end
      if (!cpu_ack && !dma_ack) chk("err_without_ack", {31'd0, err}, 32'd0);
      if (log_en && (cpu_gnt || dma_gnt)) glog.push_back(cpu_gnt ? 2'd1 : 2'd2);
      pc <= cpu_gnt; pd <= dma_gnt;
    end
  end

  task automatic check_order(input string name);
    chk({name, "_len"}, glog.size(), 32'd6);
    for (int i = 0; i < glog.size() && i < 6; i++)
      chk(name, {30'd0, glog[i]}, (i % 2 == 0) ? 32'd1 : 32'd2);
  endtask

  initial begin
    int lat;
    for (int i = 0; i < 65536; i++) begin mem[i] = 8'h00; rmem[i] = 8'h00; end

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_gnt",   {30'd0, cpu_gnt, dma_gnt}, 32'd0);
    chk("rst_ack",   {29'd0, cpu_ack, dma_ack, err}, 32'd0);
    chk("rst_rdata", {cpu_rdata, dma_rdata}, 32'd0);
    chk("rst_ramrw", {31'd0, ram_RW}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Simultaneous requests from IDLE after reset: C, D, C, D, C, D.
    log_en = 1;
    fork
      begin
        for (int i = 0; i < 3; i++) cpu_access(16'h0280 + 16'(i*2), 16'h0, 1'b0, 1'b0, lat);
        cpu_req = 1'b0;
      end
      begin
        for (int i = 0; i < 3; i++) dma_access(16'h0380 + 16'(i*2), 16'h0, 1'b0, 1'b0, lat);
        dma_req = 1'b0;
      end
    join
    log_en = 0;
    check_order("grant_order");
    glog.delete();
    @(negedge clk);

    // CPU word write then read back, latency two cycles from req.
    cpu_access(16'h0210, 16'hBEEF, 1'b1, 1'b0, lat);
    chk("cpu_wr_latency", lat, 32'd2);
    cpu_access(16'h0210, 16'h0000, 1'b0, 1'b0, lat);
    chk("cpu_rd_latency", lat, 32'd2);
    chk("cpu_read_beef", {16'd0, cpu_rdata}, 32'h0000BEEF);
    cpu_req = 1'b0;
    @(negedge clk);

    // DMA byte write into a word, then word and byte readback.
    dma_access(16'h0300, 16'h1234, 1'b1, 1'b0, lat);
    dma_access(16'h0301, 16'h005A, 1'b1, 1'b1, lat);
    dma_access(16'h0300, 16'h0000, 1'b0, 1'b0, lat);
    chk("dma_word_merge", {16'd0, dma_rdata}, 32'h00005A34);
    dma_access(16'h0301, 16'h0000, 1'b0, 1'b1, lat);
    chk("dma_byte_read", {16'd0, dma_rdata}, 32'h0000005A);
    dma_req = 1'b0;
    @(negedge clk);

    // Word write straddling the top of the RAM window.
    cpu_access(16'h03FF, 16'hCAFE, 1'b1, 1'b0, lat);
`ifdef RAM_ARB_RANGE_CHECK_EN
    chk("oor_err",   {31'd0, err}, 32'd1);
    chk("oor_rdata", {16'd0, cpu_rdata}, 32'd0);
`else
    chk("oor_err",   {31'd0, err}, 32'd0);
`endif
    cpu_req = 1'b0;
    @(negedge clk);

    // Reset during a CPU write grant: no write may land.
    cpu_addr = 16'h0250; cpu_din = 16'hDEAD; cpu_rw = 1'b1; cpu_bw = 1'b0; cpu_req = 1'b1;
    @(negedge clk);
    chk("pre_rst_gnt",  {31'd0, cpu_gnt}, 32'd1);
    chk("pre_rst_rw",   {31'd0, ram_RW}, 32'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_gnt",  {31'd0, cpu_gnt}, 32'd0);
    chk("rst_mid_rw",   {31'd0, ram_RW}, 32'd0);
    chk("rst_mid_ack",  {31'd0, cpu_ack}, 32'd0);
    cpu_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    log_en = 1;
    fork
      begin cpu_access(16'h0250, 16'h0, 1'b0, 1'b0, lat); cpu_req = 1'b0; end
      begin dma_access(16'h0320, 16'h0, 1'b0, 1'b0, lat); dma_req = 1'b0; end
    join
    log_en = 0;
    chk("post_rst_first_cpu", {30'd0, (glog.size() > 0) ? glog[0] : 2'd0}, 32'd1);
    chk("post_rst_unchanged", {16'd0, cpu_rdata}, 32'd0);
    glog.delete();
    @(negedge clk);

    // Random traffic in disjoint CPU/DMA regions, with occasional idles
    // and occasional accesses outside the RAM window.
    fork
      begin
        int l;
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(7) == 0) a = 16'h0180 + 16'($urandom_range(16'h7E));
          else                        a = 16'h0200 + 16'($urandom_range(16'hFE));
          cpu_access(a, 16'($urandom), 1'($urandom), 1'($urandom), l);
          if ($urandom_range(2) == 0) begin
            cpu_req = 1'b0;
            repeat ($urandom_range(3)) @(negedge clk);
          end
        end
        cpu_req = 1'b0;
      end
      begin
        int l;
        logic [15:0] a;
        for (int i = 0; i < 40; i++) begin
          if ($urandom_range(7) == 0) a = 16'h0400 + 16'($urandom_range(16'h7E));
          else                        a = 16'h0300 + 16'($urandom_range(16'hFE));
          dma_access(a, 16'($urandom), 1'($urandom), 1'($urandom), l);
          if ($urandom_range(2) == 0) begin
            dma_req = 1'b0;
            repeat ($urandom_range(3)) @(negedge clk);
          end
        end
        dma_req = 1'b0;
      end
    join

    for (int i = 0; i < 20 && (cpu_q.size() + dma_q.size()) != 0; i++) @(negedge clk);
    chk("cpu_q_drained", cpu_q.size(), 32'd0);
    chk("dma_q_drained", dma_q.size(), 32'd0);
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/ram_arbiter.md
# ram_arbiter

Two-port arbiter that shares the single-ported data RAM between the CPU memory interface and the DMA engine. Each access is a one-cycle grant, followed by a registered acknowledge carrying read data. The block also translates CPU-space addresses into RAM indices. It sits between the two requesters and the RAM, and drives all RAM control inputs.

## Interface
- BOUND_L, 16'h0200, lowest byte address mapped to RAM (index 0)
- BOUND_U, 16'h0400, first byte address above RAM; RAM size = BOUND_U − BOUND_L
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- cpu_req / dma_req  in  1  access pending; held high until matching ack
- cpu_addr / dma_addr  in  16  byte address, CPU space
- cpu_din / dma_din  in  16  write data
- cpu_rw / dma_rw  in  1  1 = write, 0 = read
- cpu_bw / dma_bw  in  1  1 = byte, 0 = word
- cpu_gnt / dma_gnt  out  1  this cycle is the requester's RAM access cycle
- cpu_ack / dma_ack  out  1  one-cycle pulse, cycle after gnt
- cpu_rdata / dma_rdata  out  16  registered read data, valid while ack = 1
- err  out  1  pulse with ack: the acked access was out of range (see Configuration)
- ram_addr  out  16  RAM index = granted addr − BOUND_L, modulo 2^16
- ram_Din  out  16  granted din
- ram_RW  out  1  granted rw, qualified by grant
- BW  out  1  granted bw
- ram_out  in  16  combinational RAM read data

## Operation
- Grant state machine, registered: IDLE, G_CPU, G_DMA. Only one gnt is high in any cycle.
- Eligibility at each edge: a requester is eligible if its req = 1 and it is not the requester granted in the ending cycle. This prevents regranting before the requester has seen ack.
- Next state:
  - both eligible: the requester not granted most recently wins; after reset, CPU wins.
  - one eligible: that requester.
  - none eligible: IDLE.
- Each grant lasts exactly one cycle. Requesters alternate every cycle when both keep req high. A lone requester is granted every other cycle.
- RAM port is combinational from the state and the granted requester's inputs.
  - In IDLE: ram_RW = 0, BW = 0, ram_addr = 0, ram_Din = 0.
  - ram_RW = rw & grant; write commits at the edge ending the grant cycle.
- At the edge ending a grant cycle:
  - rdata of the granted requester ← ram_out (also on writes, which return old contents).
  - Its ack ← 1 for one cycle.
  - Byte reads zero-extend: rdata = {8'h00, ram_out[7:0]}.
- Unacked requester's rdata holds its last value.
- Word address LSB is passed through unchanged; no alignment enforcement.

## Timing
- Reset values: state IDLE; cpu_gnt, dma_gnt, cpu_ack, dma_ack, err = 0; cpu_rdata, dma_rdata = 16'h0000; last-granted = DMA (so CPU wins first).
- Latency: req rises in cycle 0 → gnt in cycle 1 → ack and rdata in cycle 2.
- A requester deasserts req in its ack cycle, or keeps it high with new addr/din/rw/bw for the next access; that request is sampled at the end of the ack cycle.
- Requester inputs must be stable from req rise through its gnt cycle.
- Reset asserted mid-grant: outputs clear immediately, ram_RW drops combinationally, no write occurs at the next edge. Pending requests are re-arbitrated after rst_n deasserts.
- Simultaneous req rise from IDLE: CPU first, DMA next cycle.

## Configuration
- RAM_ARB_RANGE_CHECK_EN defined:
  - Range: an access is out of range if addr < BOUND_L, or addr > BOUND_U−1 (byte), or addr > BOUND_U−2 (word).
  - Grant sequencing is unchanged; ram_RW is forced 0 for the access.
  - Read data is forced 16'h0000.
  - err pulses with the ack.
- Undefined: no check, err tied 0, addresses translated with modulo-2^16 wrap.

## Structure
- Shared package: state encoding (IDLE, G_CPU, G_DMA), requester id constants, BOUND_L/BOUND_U defaults.
- One natural sub-module, ram_arb_range: combinational range check, instantiated only under the macro.

## Test plan
- CPU word write 16'hBEEF to 16'h0210, then read 16'h0210 → ram_addr 16'h0010, ram_RW = 1 in gnt cycle, read ack returns 16'hBEEF, two cycles after req.
- Both req from IDLE, held 6 cycles → grant order CPU, DMA, CPU, DMA; exactly one gnt per cycle; no regrant before ack.
- DMA byte write 8'h5A to 16'h0301 over word 16'h1234 at 16'h0300, then word read → 16'h5A34; byte read of 16'h0301 → 16'h005A.
- rst_n low during a CPU write grant → gnt, ack and ram_RW drop immediately; location unchanged afterwards; post-reset first grant is CPU.
- With RAM_ARB_RANGE_CHECK_EN: CPU word write to 16'h03FF → ram_RW stays 0, ack with err = 1, rdata 16'h0000. Without the macro: same access → err = 0, write issued at ram_addr 16'h01FF.
